// File: rtl/parallel_cpu_0_cpu_mult_seq.sv
// Sequencer around the shared 16x16 multiplier cell: 32x32 unsigned multiply returning low word
// (3 cycles) or, with MULT_SEQ_HIGH_EN defined, the high word via a second cell pass (5 cycles).
module parallel_cpu_0_cpu_mult_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op_high,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    output logic        mul_en,
    input  logic [31:0] mul_p1,
    input  logic [31:0] mul_p2,
    input  logic [31:0] mul_p3
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        CAP_LO,
`ifdef MULT_SEQ_HIGH_EN
        ISSUE_HI,
        CAP_HI,
`endif
        DONE
    } state_t;

    state_t      state, state_next;
    logic [31:0] a_q, b_q;
    logic [31:0] acc_lo, acc_lo_next;
    logic        done_next;
    logic [31:0] result_next;

`ifdef MULT_SEQ_HIGH_EN
    logic        op_high_q;
    logic [31:0] acc_hi, acc_hi_next;
    logic [32:0] mid;
    logic [63:0] sum_lo;
`else
    // Upper partial-product bits only feed acc[63:32], which does not exist in this build.
    logic        unused_hi;
    assign unused_hi = ^{op_high, mul_p2[31:16], mul_p3[31:16]};
`endif

    always_comb begin
        state_next  = state;
        mul_en      = 1'b0;
        mul_src1    = 32'd0;
        mul_src2    = 32'd0;
        acc_lo_next = acc_lo;
`ifdef MULT_SEQ_HIGH_EN
        acc_hi_next = acc_hi;
        mid         = {1'b0, mul_p2} + {1'b0, mul_p3};
        sum_lo      = {32'd0, mul_p1} + ({31'd0, mid} << 16);
`endif
        case (state)
            IDLE: begin
                if (start) state_next = ISSUE_LO;
            end
            ISSUE_LO: begin
                mul_en     = 1'b1;
                mul_src1   = a_q;
                mul_src2   = b_q;
                state_next = CAP_LO;
            end
            CAP_LO: begin
`ifdef MULT_SEQ_HIGH_EN
                acc_lo_next = sum_lo[31:0];
                acc_hi_next = sum_lo[63:32];
                state_next  = op_high_q ? ISSUE_HI : DONE;
`else
                acc_lo_next = mul_p1 + {mul_p2[15:0] + mul_p3[15:0], 16'd0};
                state_next  = DONE;
`endif
            end
`ifdef MULT_SEQ_HIGH_EN
            ISSUE_HI: begin
                mul_en     = 1'b1;
                mul_src1   = {16'd0, a_q[31:16]};
                mul_src2   = {16'd0, b_q[31:16]};
                state_next = CAP_HI;
            end
            CAP_HI: begin
                // Second pass: mul_p1 now holds a_hi*b_hi, which lands wholly in the upper word.
                acc_hi_next = acc_hi + mul_p1;
                state_next  = DONE;
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // done/result are registered, so they are loaded on the edge entering DONE.
    assign done_next = (state_next == DONE) && (state != DONE);
`ifdef MULT_SEQ_HIGH_EN
    assign result_next = op_high_q ? acc_hi_next : acc_lo_next;
`else
    assign result_next = acc_lo_next;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            acc_lo <= 32'd0;
            done   <= 1'b0;
            result <= 32'd0;
`ifdef MULT_SEQ_HIGH_EN
            op_high_q <= 1'b0;
            acc_hi    <= 32'd0;
`endif
        end else begin
            state  <= state_next;
            acc_lo <= acc_lo_next;
            done   <= done_next;
            if (done_next) result <= result_next;
            if (state == IDLE && start) begin
                a_q <= src_a;
                b_q <= src_b;
`ifdef MULT_SEQ_HIGH_EN
                op_high_q <= op_high;
`endif
            end
`ifdef MULT_SEQ_HIGH_EN
            acc_hi <= acc_hi_next;
`endif
        end
    end

endmodule

// File: tb/tb_parallel_cpu_0_cpu_mult_seq.sv
// Bench for parallel_cpu_0_cpu_mult_seq with a behavioural multiplier cell and a 64-bit product model.
module tb_parallel_cpu_0_cpu_mult_seq;

    logic        clk = 1'b0;
    logic        reset, start, op_high;
    logic [31:0] src_a, src_b;
    logic        busy, done, mul_en;
    logic [31:0] result, mul_src1, mul_src2;
    logic [31:0] mul_p1 = 32'd0, mul_p2 = 32'd0, mul_p3 = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    parallel_cpu_0_cpu_mult_seq dut (
        .clk(clk), .reset(reset), .start(start), .op_high(op_high),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
        .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3)
    );

    // Multiplier cell: registers its three 16x16 products when enabled.
    always @(posedge clk) begin
        if (mul_en) begin
            mul_p1 <= {16'd0, mul_src1[15:0]} * {16'd0, mul_src2[15:0]};
            mul_p2 <= {16'd0, mul_src1[15:0]} * {16'd0, mul_src2[31:16]};
            mul_p3 <= {16'd0, mul_src1[31:16]} * {16'd0, mul_src2[15:0]};
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
`ifdef MULT_SEQ_HIGH_EN
        return op ? p[63:32] : p[31:0];
`else
        return p[31:0];
`endif
    endfunction

    function automatic int ref_latency(input logic op);
`ifdef MULT_SEQ_HIGH_EN
        return op ? 5 : 3;
`else
        return 3;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] exp;
        int lat;
        exp = ref_word(a, b, op);
        lat = ref_latency(op);
        src_a = a; src_b = b; op_high = op; start = 1'b1;
        tick();
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; op_high = ~op;
        for (int c = 1; c <= lat; c++) begin
            check($sformatf("mul_en c%0d", c), {63'd0, mul_en}, {63'd0, (c == 1) || (c == 3 && lat == 5)});
            if (c == 1) begin
                check("src1 lo", {32'd0, mul_src1}, {32'd0, a});
                check("src2 lo", {32'd0, mul_src2}, {32'd0, b});
            end
            if (c == 3 && lat == 5) begin
                check("src1 hi", {32'd0, mul_src1}, {48'd0, a[31:16]});
                check("src2 hi", {32'd0, mul_src2}, {48'd0, b[31:16]});
            end
            check($sformatf("busy c%0d", c), {63'd0, busy}, 64'd1);
            check($sformatf("done c%0d", c), {63'd0, done}, {63'd0, c == lat});
            if (c == lat) check("result", {32'd0, result}, {32'd0, exp});
            else tick();
        end
        tick();
        check("idle busy", {63'd0, busy}, 64'd0);
        check("idle done", {63'd0, done}, 64'd0);
        check("result hold", {32'd0, result}, {32'd0, exp});
    endtask

    initial begin
        logic [31:0] a1, b1, a2;
        int          pulses;
        bit          seen;

        reset = 1'b1; start = 1'b0; op_high = 1'b0; src_a = 32'd0; src_b = 32'd0;
        tick(); tick();
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst done", {63'd0, done}, 64'd0);
        check("rst result", {32'd0, result}, 64'd0);
        check("rst mul_en", {63'd0, mul_en}, 64'd0);
        check("rst src1", {32'd0, mul_src1}, 64'd0);
        check("rst src2", {32'd0, mul_src2}, 64'd0);
        reset = 1'b0;
        tick();

        run(32'h0001_0002, 32'h0003_0004, 1'b0);
        run(32'h0001_0002, 32'h0003_0004, 1'b1);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run(32'h0000_0000, 32'hDEAD_BEEF, 1'b1);
        run(32'h8000_0000, 32'h0000_0002, 1'b1);
        for (int i = 0; i < 30; i++) run($urandom, $urandom, 1'($urandom_range(1, 0)));

        // start held high: one run on cycle-0 operands, next accept in cycle 4
        a1 = $urandom; b1 = $urandom;
        src_a = a1; src_b = b1; op_high = 1'b0; start = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            src_a = $urandom;
            check($sformatf("held done c%0d", c), {63'd0, done}, {63'd0, c == 3});
            if (c == 3) check("held result", {32'd0, result}, {32'd0, ref_word(a1, b1, 1'b0)});
            tick();
        end
        a2 = $urandom; src_a = a2;
        check("held c4 busy", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0; src_a = $urandom;
        check("held c5 busy", {63'd0, busy}, 64'd1);
        check("held c5 mul_en", {63'd0, mul_en}, 64'd1);
        check("held c5 src1", {32'd0, mul_src1}, {32'd0, a2});
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = done;
        end
        check("held 2nd done seen", {63'd0, seen}, 64'd1);
        check("held 2nd result", {32'd0, result}, {32'd0, ref_word(a2, b1, 1'b0)});
        tick();

        // reset asserted in cycle 2 aborts the run with no done
        src_a = $urandom; src_b = $urandom; op_high = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort result", {32'd0, result}, 64'd0);
        check("abort mul_en", {63'd0, mul_en}, 64'd0);
        check("abort src1", {32'd0, mul_src1}, 64'd0);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) pulses++;
        end
        check("abort no done", 64'(pulses), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
